a2d_spi_resp: RTL
=================

// Module: a2d_spi_resp
// PURPOSE
//  SPI responder for the 8-channel 12-bit A2D (ADC128S-style) on A2D_SS_n/SCLK/MOSI/MISO.
//  - Answers the A2D interface's transactions from an internal 8x12 channel register file.
//  - The file is loaded through a simple write port.
//  - Used as the A2D end in full-chip benches and FPGA self-test builds (load cells, batt, steer_pot).
// PARAMETERS
//  RST_VAL   12'h000  reset contents of all eight channel registers
//  SYNC_STG  2        metastability flops on SS_n/SCLK/MOSI before the edge-detect flop (2 or 3)
// PORTS
//  clk      in   1   system clock
//  rst_n    in   1   asynchronous active-low reset
//  SS_n     in   1   SPI slave select, active low (async to clk)
//  SCLK     in   1   SPI clock, mode 0 (async to clk)
//  MOSI     in   1   SPI data from master
//  MISO     out  1   SPI data to master; 1'bz while deselected
//  wr_en    in   1   write strobe for channel register file
//  wr_chnl  in   3   channel written when wr_en
//  wr_data  in   12  value written when wr_en
//  cur_chnl out  3   channel latched by last completed transaction
//  done     out  1   1-clk pulse when a full 16-bit transaction completes
// BEHAVIOUR
//  Reset:
//   - chan regs = RST_VAL; cur_chnl = 0; done = 0; state = IDLE.
//   - shift regs = 0; MISO = z.
//  Sync and edges:
//   - SS_n, SCLK and MOSI each pass through SYNC_STG flops plus one edge flop.
//     ss_n flops preset to 1 on reset.
//   - Edges are decoded from the last two flops:
//     sclk_rise, sclk_fall, ss_fall, ss_rise.
//   - SCLK high/low phases must each be >= 4 clk.
//   - MISO changes <= SYNC_STG+2 clk after a real SCLK fall.
//  Frame: 16 bits, MSB first.
//   - MOSI word = {2'bxx, chnl[2:0], 11'bx}; bits[13:11] select the next channel.
//   - MISO word = {4'b0000, val[11:0]}; val = regs[cur_chnl], snapshotted at ss_fall.
//  FSM IDLE -> SHIFT -> DONE -> IDLE:
//   - IDLE: MISO = z.
//     On ss_fall: tx_shft <= {4'b0,regs[cur_chnl]}, bit_cnt <= 0, drive MISO = tx_shft[15]
//     (bit15 = 0 valid before first rise), go to SHIFT.
//   - SHIFT: on sclk_rise, rx_shft <= {rx_shft[14:0],MOSI}, bit_cnt++.
//     On sclk_fall with bit_cnt != 0, tx_shft <<= 1 (MISO = new MSB).
//     After the 16th rise, go to DONE.
//     ss_rise before 16 rises = abort: back to IDLE; cur_chnl unchanged; no done.
//   - DONE: wait for ss_rise (extra SCLK edges ignored).
//     On ss_rise: cur_chnl <= rx_shft[13:11], done = 1 for exactly one clk, go to IDLE, MISO = z.
//  Reg file:
//   - wr_en writes regs[wr_chnl] on the next clk edge, at any time.
//   - A write in the same clk as ss_fall: the snapshot gets the OLD value; the new value applies from the next transaction.
//   - A write during SHIFT does not alter bits in flight.
//  Reset mid-frame: immediate return to IDLE with reset values; master must re-assert SS_n.
//  Two-frame read protocol (master side):
//   - frame N carries the channel command;
//   - frame N+1 returns that channel's value.
// TESTING
//  1. Reset, no writes: 16-bit frame with MOSI=16'h0000 -> MISO 16'h0000, done pulses once, cur_chnl=0.
//  2. regs[4]=12'hABC; frame MOSI=16'h2000 then frame MOSI=16'h0000 -> 2nd MISO=16'h0ABC, cur_chnl 4 -> 0.
//  3. regs[5]=12'h7FF, regs[6]=12'h123; three frames cmd 5,6,0 -> frames 2,3 return 16'h07FF, 16'h0123.
//  4. Abort: cmd ch 3 frame cut after 9 SCLKs (SS_n high) -> no done, cur_chnl stays previous; next frame returns old channel.
//  5. wr_en to regs[cur_chnl] same clk as ss_fall (old 12'h111, new 12'h222) -> frame gives 16'h0111, next gives 16'h0222.
//  6. rst_n low mid-SHIFT -> MISO=z, cur_chnl=0, regs=RST_VAL; a following clean frame still completes correctly.

Source files
------------

// File: rtl/a2d_spi_resp_if.sv
// Bundle of the A2D responder's SPI-side inputs, register-file write port and status outputs.
// MISO is a tristate line, so it stays a plain port on the responder rather than living here.
interface a2d_spi_resp_if;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        wr_en;
   logic [2:0]  wr_chnl;
   logic [11:0] wr_data;
   logic [2:0]  cur_chnl;
   logic        done;

   modport slave (
      input  SS_n, SCLK, MOSI, wr_en, wr_chnl, wr_data,
      output cur_chnl, done
   );

   modport master (
      output SS_n, SCLK, MOSI, wr_en, wr_chnl, wr_data,
      input  cur_chnl, done
   );
endinterface

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating an 8-channel 12-bit A2D.
// Each frame returns the channel selected by the previous frame, read from a loadable register file.
module a2d_spi_resp #(
   parameter logic [11:0] RST_VAL  = 12'h000,
   parameter int          SYNC_STG = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   a2d_spi_resp_if.slave spi,
   output wire           MISO
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state_q, state_d;
   logic [SYNC_STG:0] ss_q, sclk_q, mosi_q;
   logic [11:0]       regs_q [8];
   logic [15:0]       tx_shft_q, tx_shft_d;
   logic [15:0]       rx_shft_q, rx_shft_d;
   logic [4:0]        bit_cnt_q, bit_cnt_d;
   logic [2:0]        cur_chnl_q, cur_chnl_d;
   logic              done_q, done_d;
   logic              ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

   // SS_n resets high so releasing reset never looks like a select edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_q   <= '1;
         sclk_q <= '0;
         mosi_q <= '0;
      end else begin
         ss_q   <= {ss_q[SYNC_STG-1:0], spi.SS_n};
         sclk_q <= {sclk_q[SYNC_STG-1:0], spi.SCLK};
         mosi_q <= {mosi_q[SYNC_STG-1:0], spi.MOSI};
      end
   end

   assign ss_fall   =  ss_q[SYNC_STG]   & ~ss_q[SYNC_STG-1];
   assign ss_rise   = ~ss_q[SYNC_STG]   &  ss_q[SYNC_STG-1];
   assign sclk_rise = ~sclk_q[SYNC_STG] &  sclk_q[SYNC_STG-1];
   assign sclk_fall =  sclk_q[SYNC_STG] & ~sclk_q[SYNC_STG-1];
   assign mosi_s    =  mosi_q[SYNC_STG-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) regs_q[i] <= RST_VAL;
      end else if (spi.wr_en) begin
         regs_q[spi.wr_chnl] <= spi.wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tx_shft_q  <= '0;
         rx_shft_q  <= '0;
         bit_cnt_q  <= '0;
         cur_chnl_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_shft_q  <= tx_shft_d;
         rx_shft_q  <= rx_shft_d;
         bit_cnt_q  <= bit_cnt_d;
         cur_chnl_q <= cur_chnl_d;
         done_q     <= done_d;
      end
   end

   // The snapshot reads the registered file, so a write landing on the select edge is seen next frame
   always_comb begin
      state_d    = state_q;
      tx_shft_d  = tx_shft_q;
      rx_shft_d  = rx_shft_q;
      bit_cnt_d  = bit_cnt_q;
      cur_chnl_d = cur_chnl_q;
      done_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ss_fall) begin
               tx_shft_d = {4'b0000, regs_q[cur_chnl_q]};
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               state_d = IDLE;
            end else if (sclk_rise) begin
               rx_shft_d = {rx_shft_q[14:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd15) state_d = DONE;
            end else if (sclk_fall && (bit_cnt_q != 5'd0)) begin
               tx_shft_d = {tx_shft_q[14:0], 1'b0};
            end
         end
         DONE: begin
            if (ss_rise) begin
               cur_chnl_d = rx_shft_q[13:11];
               done_d     = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign MISO         = (state_q == IDLE) ? 1'bz : tx_shft_q[15];
   assign spi.cur_chnl = cur_chnl_q;
   assign spi.done     = done_q;

endmodule
